// File: rtl/nanov_digit_alu_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, FSM encoding and
// the step-count helper used at operation acceptance.
package nanov_digit_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

  // Shifts move one bit per step (a zero amount still takes one idle step);
  // everything else walks the operand one digit per step.
  function automatic int unsigned calc_steps(input int unsigned xlen,
                                             input int unsigned dw,
                                             input logic [2:0]  f3,
                                             input int unsigned shamt);
    int unsigned n;
    if (is_shift(f3)) begin
      n = (shamt == 32'd0) ? 32'd1 : shamt;
    end else begin
      n = xlen / dw;
    end
    return n;
  endfunction

endpackage

// File: rtl/nanov_digit_alu_slice.sv
// One DW-bit digit of the ALU: add/subtract with carry, bitwise logic and
// a raw digit-equality flag for the serial a==b compare.
module nanov_digit_alu_slice
  import nanov_digit_alu_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic          i_cin,
  input  logic          i_inv_b,
  input  logic [2:0]    i_f3,
  output logic [DW-1:0] o_y,
  output logic          o_cout,
  output logic          o_eq
);

  logic [DW-1:0] w_b;
  logic [DW:0]   w_sum;

  // Digit arithmetic and logic; equality always uses the uninverted b.
  always_comb begin
    w_b    = i_inv_b ? ~i_b : i_b;
    w_sum  = {1'b0, i_a} + {1'b0, w_b} + {{DW{1'b0}}, i_cin};
    o_cout = w_sum[DW];
    o_eq   = (i_a == i_b);
    case (i_f3)
      F3_XOR:  o_y = i_a ^ i_b;
      F3_OR:   o_y = i_a | i_b;
      F3_AND:  o_y = i_a & i_b;
      default: o_y = w_sum[DW-1:0];
    endcase
  end

endmodule

// File: rtl/nanov_digit_alu.sv
// Digit-serial ALU: operands are captured on start, then processed one digit
// (or, for shifts, one bit) per cycle; result and cmp are held until the next op.
module nanov_digit_alu
  import nanov_digit_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DW   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_start,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_cmp
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [3:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_last_cnt;
  logic            r_carry;
  logic            r_eq;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic            r_cmp;

  logic            w_accept;
  logic            w_last;
  logic [2:0]      w_f3;
  logic            w_shift;
  logic            w_inv_b;
  logic            w_cin;
  logic [DW-1:0]   w_y;
  logic            w_cout;
  logic            w_eq_dig;
  logic            w_flag;
  logic [XLEN-1:0] w_sh_val;
  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0] w_final_res;
  logic            w_final_cmp;
  logic [CW-1:0]   w_last_in;

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_cmp    = r_cmp;

  nanov_digit_alu_slice #(.DW(DW)) u_slice (
    .i_a     (r_a[DW-1:0]),
    .i_b     (r_b[DW-1:0]),
    .i_cin   (w_cin),
    .i_inv_b (w_inv_b),
    .i_f3    (w_f3),
    .o_y     (w_y),
    .o_cout  (w_cout),
    .o_eq    (w_eq_dig)
  );

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-step datapath: carry chain, SLT/SLTU flag, shifter and final result mux.
  always_comb begin
    w_f3      = r_op[2:0];
    w_shift   = is_shift(w_f3);
    w_inv_b   = ((w_f3 == F3_ADD) && r_op[3]) || (w_f3 == F3_SLT) || (w_f3 == F3_SLTU);
    w_cin     = (r_cnt == {CW{1'b0}}) ? w_inv_b : r_carry;
    w_last    = (r_cnt == r_last_cnt);
    w_acc_nxt = (r_acc >> DW) | (XLEN'(w_y) << (XLEN - DW));
    w_last_in = CW'(calc_steps(XLEN, DW, i_op[2:0], 32'(i_b[SW-1:0])) - 32'd1);

    // On the final step the current digit is the top one, so its MSBs are the operand signs.
    if (w_f3 == F3_SLTU) begin
      w_flag = ~w_cout;
    end else if (r_a[DW-1] != r_b[DW-1]) begin
      w_flag = r_a[DW-1];
    end else begin
      w_flag = w_y[DW-1];
    end

    if (r_b[SW-1:0] == {SW{1'b0}}) begin
      w_sh_val = r_a;
    end else begin
      case (w_f3)
        F3_SLL:  w_sh_val = r_a << 1;
        F3_SR:   w_sh_val = r_op[3] ? {r_a[XLEN-1], r_a[XLEN-1:1]} : (r_a >> 1);
        default: w_sh_val = r_a;
      endcase
    end

    if (w_shift) begin
      w_final_res = w_sh_val;
      w_final_cmp = r_eq;
    end else if ((w_f3 == F3_SLT) || (w_f3 == F3_SLTU)) begin
      w_final_res = {{(XLEN-1){1'b0}}, w_flag};
      w_final_cmp = w_flag;
    end else begin
      w_final_res = w_acc_nxt;
      w_final_cmp = r_eq & w_eq_dig;
    end
  end

  // State, operand registers and held outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_a        <= {XLEN{1'b0}};
      r_b        <= {XLEN{1'b0}};
      r_acc      <= {XLEN{1'b0}};
      r_op       <= 4'b0000;
      r_cnt      <= {CW{1'b0}};
      r_last_cnt <= {CW{1'b0}};
      r_carry    <= 1'b0;
      r_eq       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= {XLEN{1'b0}};
      r_cmp      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_a        <= i_a;
        r_b        <= i_b;
        r_op       <= i_op;
        r_acc      <= {XLEN{1'b0}};
        r_cnt      <= {CW{1'b0}};
        r_carry    <= 1'b0;
        r_last_cnt <= w_last_in;
        // Shifts never walk the digits, so their a==b flag is taken up front.
        r_eq       <= is_shift(i_op[2:0]) ? (i_a == i_b) : 1'b1;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_shift) begin
          r_a <= w_sh_val;
        end else begin
          r_a     <= r_a >> DW;
          r_b     <= r_b >> DW;
          r_acc   <= w_acc_nxt;
          r_carry <= w_cout;
          r_eq    <= r_eq & w_eq_dig;
        end
        if (w_last) begin
          r_result <= w_final_res;
          r_cmp    <= w_final_cmp;
        end
      end
    end
  end

endmodule
